bank_write_scatter: RTL

BANK_WRITE_SCATTER -- requirements
Module: bank_write_scatter

---
 rtl/bank_write_scatter.sv | 101 ++++++++++
 1 files changed

// File: rtl/bank_write_scatter.sv
// rtl/bank_write_scatter.sv - scatter a multi-lane write burst into conflict-free per-bank rounds
module bank_write_scatter #(
  parameter int BW     = 16,
  parameter int N_LANE = 16,
  parameter int N_BANK = 8,
  parameter int BBW    = $clog2(N_BANK)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     src_rdy,
  output logic                     src_ack,
  input  logic [N_LANE*BW-1:0]     i_data,
  input  logic [N_LANE*BBW-1:0]    i_bank,
  input  logic [N_LANE-1:0]        i_lane_en,
  output logic                     dst_rdy,
  input  logic                     dst_ack,
  output logic [N_BANK*BW-1:0]     o_data,
  output logic [N_BANK-1:0]        o_mask,
  output logic [N_BANK*N_LANE-1:0] o_routing,
  output logic                     o_last
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state, state_nxt;
  logic [N_LANE-1:0]       pending, pending_nxt;
  logic [N_LANE-1:0]       lane_ok;
  logic [N_LANE-1:0]       granted;
  logic [N_BANK-1:0]       taken;
  logic [N_LANE*BW-1:0]    data_r;
  logic [N_LANE*BBW-1:0]   bank_r;

  // Lanes aimed at a nonexistent bank never enter pending.
  always_comb begin
    lane_ok = '0;
    for (int j = 0; j < N_LANE; j++) begin
      lane_ok[j] = ({1'b0, i_bank[j*BBW +: BBW]} < (BBW+1)'(N_BANK));
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    src_ack     = (state == IDLE);
    dst_rdy     = (state == BUSY);
    case (state)
      IDLE: begin
        if (src_rdy) begin
          pending_nxt = i_lane_en & lane_ok;
          if (pending_nxt != '0) state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (dst_ack) begin
          pending_nxt = pending & ~granted;
          if (pending_nxt == '0) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= IDLE;
      pending <= '0;
      data_r  <= '0;
      bank_r  <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      if (state == IDLE && src_rdy) begin
        data_r <= i_data;
        bank_r <= i_bank;
      end
    end
  end

  // Per bank, the lowest-index pending lane wins; everything here is a
  // function of registered state only.
  always_comb begin
    taken     = '0;
    granted   = '0;
    o_routing = '0;
    o_data    = '0;
    for (int b = 0; b < N_BANK; b++) begin
      for (int j = 0; j < N_LANE; j++) begin
        if (!taken[b] && pending[j] && bank_r[j*BBW +: BBW] == BBW'(b)) begin
          taken[b]                = 1'b1;
          granted[j]              = 1'b1;
          o_routing[b*N_LANE + j] = 1'b1;
          o_data[b*BW +: BW]      = data_r[j*BW +: BW];
        end
      end
    end
  end

  assign o_mask = taken;
  assign o_last = (state == BUSY) && ((pending & ~granted) == '0);

endmodule
